lmi_bus_arb: RTL and testbench

Arbiter and sequencer for the LMI external memory bus. Shares the bus between three requesters: I-cache line fill/uncached fetch (IC), D-cache line fill/uncached load (DC) and write-buffer drain (WB). It chooses one owner, runs the external request/grant handshake, counts data beats to the end of the burst and returns ownership. Its grant outputs are the source of the per-cache "other requester busy" and "acknowledge" qualifiers used by the cache state machines.

---
 rtl/lmi_symbols.sv | 31 +++
 rtl/lmi_arb_prio.sv | 27 ++
 rtl/lmi_bus_arb.sv | 160 ++++++++++++++++
 tb/tb_lmi_bus_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lmi_symbols.sv
// Shared symbols for the LMI bus arbiter: FSM state bit indices,
// requester indices and line-burst sizing constants.
package lmi_symbols;

    // One-hot FSM state bit positions
    localparam int ARB_ST_IDLE = 0;
    localparam int ARB_ST_REQ  = 1;
    localparam int ARB_ST_XFER = 2;
    localparam int ARB_ST_TURN = 3;
    localparam int ARB_ST_LAST = ARB_ST_TURN;

    // Requester bit positions in REQ/GNT vectors
    localparam int ARB_IC   = 0;
    localparam int ARB_DC   = 1;
    localparam int ARB_WB   = 2;
    localparam int ARB_NREQ = 3;

    // Default burst length and the beat index of its final beat
    localparam int LMI_LINE_BEATS = 4;
    localparam int LINE_CTR_LAST  = LMI_LINE_BEATS - 1;

    // Watchdog counter width, clamped to 8..16 bits
    function automatic int wdog_width(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 8) w = 8;
        if (w > 16) w = 16;
        return w;
    endfunction

endpackage

// File: rtl/lmi_arb_prio.sv
// Winner select for the LMI bus: urgent WB, then round-robin
// IC/DC, then WB. Result is one-hot (all zero if no request).
module lmi_arb_prio
    import lmi_symbols::*;
(
    input  logic [ARB_NREQ-1:0] i_req,
    input  logic                i_urgent,
    input  logic                i_rr_dc,
    output logic [ARB_NREQ-1:0] o_win
);

    // Fixed priority chain with the IC/DC preference taken from i_rr_dc
    always_comb begin
        o_win = '0;
        if (i_req[ARB_WB] && i_urgent)
            o_win[ARB_WB] = 1'b1;
        else if (!i_rr_dc && i_req[ARB_IC])
            o_win[ARB_IC] = 1'b1;
        else if (i_req[ARB_DC])
            o_win[ARB_DC] = 1'b1;
        else if (i_req[ARB_IC])
            o_win[ARB_IC] = 1'b1;
        else if (i_req[ARB_WB])
            o_win[ARB_WB] = 1'b1;
    end

endmodule

// File: rtl/lmi_bus_arb.sv
// LMI external bus arbiter/sequencer for IC, DC and WB requesters.
// Optional watchdog enabled by defining LMI_ARB_TIMEOUT_EN.
module lmi_bus_arb
    import lmi_symbols::*;
#(
    parameter int LINE_BEATS     = LMI_LINE_BEATS,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          CLK,
    input  logic                          RESET_N,
    input  logic                          IC_REQ,
    input  logic                          DC_REQ,
    input  logic                          WB_REQ,
    input  logic                          IC_LINE,
    input  logic                          DC_LINE,
    input  logic                          WB_URGENT,
    output logic                          IC_GNT,
    output logic                          DC_GNT,
    output logic                          WB_GNT,
    output logic                          BUS_REQ,
    output logic                          BUS_LINE,
    input  logic                          BUS_GNT,
    input  logic                          BUS_ACK,
    input  logic                          BUS_ERR,
    output logic [$clog2(LINE_BEATS)-1:0] BEAT_CTR,
    output logic                          LAST,
    output logic                          ERR
);

    localparam int CW = $clog2(LINE_BEATS);
    localparam int SW = ARB_ST_LAST + 1;
    typedef logic [SW-1:0] st_t;

    localparam st_t ST_IDLE = st_t'(1 << ARB_ST_IDLE);
    localparam st_t ST_REQ  = st_t'(1 << ARB_ST_REQ);
    localparam st_t ST_XFER = st_t'(1 << ARB_ST_XFER);
    localparam st_t ST_TURN = st_t'(1 << ARB_ST_TURN);
    localparam logic [CW-1:0] CTR_LAST = CW'(LINE_BEATS - 1);

    st_t                 r_state;
    st_t                 w_state_nxt;
    logic [ARB_NREQ-1:0] r_gnt;
    logic                r_line;
    logic [CW-1:0]       r_ctr;
    logic                r_rr_dc;

    logic [ARB_NREQ-1:0] w_req;
    logic [ARB_NREQ-1:0] w_win;
    logic                w_own_req;
    logic                w_final;
    logic                w_err;
    logic                w_last;
    logic                w_tout;

    assign w_req     = {WB_REQ, DC_REQ, IC_REQ};
    assign w_own_req = |(r_gnt & w_req);
    assign w_final   = r_line ? (r_ctr == CTR_LAST) : 1'b1;
    assign w_err     = r_state[ARB_ST_XFER] & (BUS_ERR | w_tout);
    assign w_last    = r_state[ARB_ST_XFER] & BUS_ACK & ~w_err & w_final;

    lmi_arb_prio u_prio (
        .i_req    (w_req),
        .i_urgent (WB_URGENT),
        .i_rr_dc  (r_rr_dc),
        .o_win    (w_win)
    );

`ifdef LMI_ARB_TIMEOUT_EN
    localparam int TW = wdog_width(TIMEOUT_CYCLES);
    logic [TW-1:0] r_wdog;

    assign w_tout = r_state[ARB_ST_XFER] & ~BUS_ACK &
                    (r_wdog == TW'(TIMEOUT_CYCLES - 1));

    // Count consecutive ACK-less transfer cycles
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_wdog <= '0;
        else if (r_state[ARB_ST_XFER] && !BUS_ACK)
            r_wdog <= r_wdog + 1'b1;
        else
            r_wdog <= '0;
    end
`else
    logic w_unused_to;
    assign w_tout      = 1'b0;
    assign w_unused_to = (TIMEOUT_CYCLES != 0);
`endif

    // State register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state decode; a grant beats a same-cycle request drop
    always_comb begin
        w_state_nxt = r_state;
        unique case (1'b1)
            r_state[ARB_ST_IDLE]:
                if (|w_req) w_state_nxt = ST_REQ;
            r_state[ARB_ST_REQ]:
                if (BUS_GNT)         w_state_nxt = ST_XFER;
                else if (!w_own_req) w_state_nxt = ST_IDLE;
            r_state[ARB_ST_XFER]:
                if (w_last || w_err) w_state_nxt = ST_TURN;
            r_state[ARB_ST_TURN]:
                w_state_nxt = ST_IDLE;
            default:
                w_state_nxt = ST_IDLE;
        endcase
    end

    // Ownership, burst type, beat counter and round-robin pointer
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_gnt   <= '0;
            r_line  <= 1'b0;
            r_ctr   <= '0;
            r_rr_dc <= 1'b0;
        end else begin
            if (r_state[ARB_ST_IDLE] && |w_req) begin
                r_gnt  <= w_win;
                r_line <= (w_win[ARB_IC] & IC_LINE) |
                          (w_win[ARB_DC] & DC_LINE);
                r_ctr  <= '0;
            end
            if (r_state[ARB_ST_REQ] && !BUS_GNT && !w_own_req) begin
                r_gnt  <= '0;
                r_line <= 1'b0;
            end
            if (r_state[ARB_ST_XFER]) begin
                if (BUS_ACK && !w_err)
                    r_ctr <= r_ctr + 1'b1;
                if (w_last || w_err) begin
                    r_gnt  <= '0;
                    r_line <= 1'b0;
                end
                if (w_last && !r_gnt[ARB_WB])
                    r_rr_dc <= ~r_rr_dc;
            end
        end
    end

    // Outputs decoded from registered state and live ACK/ERR
    always_comb begin
        BUS_REQ = r_state[ARB_ST_REQ];
        LAST    = w_last;
        ERR     = w_err;
    end

    assign IC_GNT   = r_gnt[ARB_IC];
    assign DC_GNT   = r_gnt[ARB_DC];
    assign WB_GNT   = r_gnt[ARB_WB];
    assign BUS_LINE = r_line;
    assign BEAT_CTR = r_ctr;

endmodule

// File: tb/tb_lmi_bus_arb.sv
// Scoreboard bench for lmi_bus_arb: stimulus queues expected
// grant/last/err/release events, a negedge monitor checks them.
module tb_lmi_bus_arb;

    localparam int LB = 4;
    localparam int TO = 8;

    localparam int K_GNT  = 0;
    localparam int K_LAST = 1;
    localparam int K_ERR  = 2;
    localparam int K_DROP = 3;

    localparam logic [2:0] O_IC = 3'b001;
    localparam logic [2:0] O_DC = 3'b010;
    localparam logic [2:0] O_WB = 3'b100;

    logic CLK = 1'b0;
    logic RESET_N;
    logic IC_REQ, DC_REQ, WB_REQ;
    logic IC_LINE, DC_LINE, WB_URGENT;
    logic IC_GNT, DC_GNT, WB_GNT;
    logic BUS_REQ, BUS_LINE;
    logic BUS_GNT, BUS_ACK, BUS_ERR;
    logic [$clog2(LB)-1:0] BEAT_CTR;
    logic LAST, ERR;

    typedef struct {
        int kind;
        int a;
        int b;
    } ev_t;

    ev_t q[$];
    int  n_chk = 0;
    int  n_pass = 0;

    always #5 CLK = ~CLK;

    lmi_bus_arb #(
        .LINE_BEATS     (LB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .IC_REQ    (IC_REQ),
        .DC_REQ    (DC_REQ),
        .WB_REQ    (WB_REQ),
        .IC_LINE   (IC_LINE),
        .DC_LINE   (DC_LINE),
        .WB_URGENT (WB_URGENT),
        .IC_GNT    (IC_GNT),
        .DC_GNT    (DC_GNT),
        .WB_GNT    (WB_GNT),
        .BUS_REQ   (BUS_REQ),
        .BUS_LINE  (BUS_LINE),
        .BUS_GNT   (BUS_GNT),
        .BUS_ACK   (BUS_ACK),
        .BUS_ERR   (BUS_ERR),
        .BEAT_CTR  (BEAT_CTR),
        .LAST      (LAST),
        .ERR       (ERR)
    );

    function automatic string kname(input int k);
        case (k)
            K_GNT:   return "grant";
            K_LAST:  return "last";
            K_ERR:   return "err";
            default: return "release";
        endcase
    endfunction

    task automatic push(input int k, input int a, input int b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        q.push_back(e);
    endtask

    task automatic check_ev(input int k, input int a, input int b);
        ev_t e;
        n_chk++;
        if (q.size() == 0) begin
            $display("FAIL %s: unexpected event a=%0d b=%0d, required none",
                     kname(k), a, b);
        end else begin
            e = q.pop_front();
            if (e.kind == k && e.a == a && (e.b < 0 || e.b == b))
                n_pass++;
            else
                $display("FAIL %s: got %s a=%0d b=%0d, required %s a=%0d b=%0d",
                         kname(k), kname(k), a, b, kname(e.kind), e.a, e.b);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic clr_req(input logic [2:0] own);
        if (own[0]) IC_REQ = 1'b0;
        if (own[1]) DC_REQ = 1'b0;
        if (own[2]) WB_REQ = 1'b0;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (IC_GNT || DC_GNT || WB_GNT) begin
                ok = 1'b1;
                break;
            end
        end
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL grant_wait: got no grant in 20 cycles, required one");
    endtask

    // Runs one transfer; returns in the TURN cycle
    task automatic run_xfer(input logic [2:0] own, input int gap,
                            input int gdel, input int nack,
                            input int err_at, input bit line,
                            input bit drop_at_gnt);
        bit ok;
        push(K_GNT, int'(own), gap);
        if (err_at > 0) begin
            push(K_ERR, int'(own), -1);
            push(K_DROP, gdel + 1 + err_at, -1);
        end else begin
            push(K_LAST, line ? LB - 1 : 0, int'(own));
            push(K_DROP, gdel + 1 + nack, -1);
        end
        wait_gnt(ok);
        if (!ok) return;
        idle(gdel);
        BUS_GNT = 1'b1;
        if (drop_at_gnt) clr_req(own);
        idle(1);
        BUS_GNT = 1'b0;
        for (int i = 0; i < nack; i++) begin
            BUS_ACK = 1'b1;
            BUS_ERR = (i + 1 == err_at);
            if (line && err_at == 0) chk("beat_ctr", int'(BEAT_CTR), i);
            idle(1);
        end
        BUS_ACK = 1'b0;
        BUS_ERR = 1'b0;
    endtask

    // Monitor: turns output activity into events for the scoreboard
    initial begin
        logic [2:0] g;
        logic [2:0] m_prev;
        int m_len;
        int m_gap;
        m_prev = '0;
        m_len  = 0;
        m_gap  = 100;
        forever begin
            @(negedge CLK);
            if (!RESET_N) begin
                m_prev = '0;
                m_len  = 0;
                m_gap  = 100;
            end else begin
                g = {WB_GNT, DC_GNT, IC_GNT};
                if (g != 0 && m_prev == 0) begin
                    check_ev(K_GNT, int'(g), m_gap);
                    m_len = 0;
                end
                if (LAST) check_ev(K_LAST, int'(BEAT_CTR), int'(g));
                if (ERR) check_ev(K_ERR, int'(g), 0);
                if (g == 0 && m_prev != 0) check_ev(K_DROP, m_len, 0);
                if (g != 0) begin
                    m_len++;
                    m_gap = 0;
                end else begin
                    m_gap++;
                end
                m_prev = g;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at 100000, required finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        RESET_N = 1'b0;
        IC_REQ = 0; DC_REQ = 0; WB_REQ = 0;
        IC_LINE = 0; DC_LINE = 0; WB_URGENT = 0;
        BUS_GNT = 0; BUS_ACK = 0; BUS_ERR = 0;
        idle(2);
        chk("rst_ic_gnt", IC_GNT, 0);
        chk("rst_dc_gnt", DC_GNT, 0);
        chk("rst_wb_gnt", WB_GNT, 0);
        chk("rst_bus_req", BUS_REQ, 0);
        chk("rst_bus_line", BUS_LINE, 0);
        chk("rst_last", LAST, 0);
        chk("rst_err", ERR, 0);
        chk("rst_beat_ctr", int'(BEAT_CTR), 0);
        RESET_N = 1'b1;
        idle(2);

        // IC line burst, grant after 2 REQ cycles, 4 ACKs
        IC_REQ = 1; IC_LINE = 1;
        run_xfer(O_IC, -1, 2, 4, 0, 1, 0);
        IC_REQ = 0; IC_LINE = 0;
        idle(3);

        // IC and DC held, singles; pointer now prefers DC
        IC_REQ = 1; DC_REQ = 1;
        run_xfer(O_DC, -1, 0, 1, 0, 0, 0);
        run_xfer(O_IC, 2, 0, 1, 0, 0, 0);
        run_xfer(O_DC, 2, 0, 1, 0, 0, 0);
        run_xfer(O_IC, 2, 0, 1, 0, 0, 0);
        IC_REQ = 0; DC_REQ = 0;
        idle(3);

        // Reset pointer, then urgent WB first, IC, DC
        RESET_N = 1'b0;
        idle(1);
        RESET_N = 1'b1;
        idle(1);
        IC_REQ = 1; DC_REQ = 1; WB_REQ = 1; WB_URGENT = 1;
        run_xfer(O_WB, -1, 1, 1, 0, 0, 0);
        WB_REQ = 0; WB_URGENT = 0;
        run_xfer(O_IC, 2, 0, 1, 0, 0, 0);
        IC_REQ = 0;
        run_xfer(O_DC, 2, 0, 1, 0, 0, 0);
        DC_REQ = 0;
        idle(3);

        // Move pointer to DC, then DC cancels before BUS_GNT
        IC_REQ = 1;
        run_xfer(O_IC, -1, 0, 1, 0, 0, 0);
        IC_REQ = 0;
        idle(3);
        DC_REQ = 1;
        push(K_GNT, int'(O_DC), -1);
        push(K_DROP, 2, -1);
        wait_gnt(ok);
        idle(1);
        DC_REQ = 0;
        idle(1);
        chk("cancel_dc_gnt", DC_GNT, 0);
        chk("cancel_bus_req", BUS_REQ, 0);
        IC_REQ = 1; DC_REQ = 1;
        run_xfer(O_DC, 1, 0, 1, 0, 0, 0);
        IC_REQ = 0; DC_REQ = 0;
        idle(3);

        // Grant and request drop in the same cycle: grant wins
        IC_REQ = 1;
        run_xfer(O_IC, -1, 0, 1, 0, 0, 1);
        idle(3);

        // DC line with BUS_ERR on the 2nd ACK; pointer stays on DC
        DC_REQ = 1; DC_LINE = 1;
        run_xfer(O_DC, -1, 0, 2, 2, 1, 0);
        DC_REQ = 0; DC_LINE = 0;
        idle(2);
        IC_REQ = 1; DC_REQ = 1;
        run_xfer(O_DC, -1, 0, 1, 0, 0, 0);
        IC_REQ = 0; DC_REQ = 0;
        idle(3);

        // Asynchronous reset during beat 2 of an IC line
        IC_REQ = 1; IC_LINE = 1;
        push(K_GNT, int'(O_IC), -1);
        wait_gnt(ok);
        BUS_GNT = 1;
        idle(1);
        BUS_GNT = 0;
        BUS_ACK = 1;
        idle(2);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_ic_gnt", IC_GNT, 0);
        chk("arst_bus_req", BUS_REQ, 0);
        chk("arst_bus_line", BUS_LINE, 0);
        chk("arst_last", LAST, 0);
        chk("arst_err", ERR, 0);
        chk("arst_beat_ctr", int'(BEAT_CTR), 0);
        BUS_ACK = 0; IC_REQ = 0; IC_LINE = 0;
        idle(1);
        RESET_N = 1'b1;
        idle(2);

        // Transfer with no ACK for a long stretch
        IC_REQ = 1;
        push(K_GNT, int'(O_IC), -1);
`ifdef LMI_ARB_TIMEOUT_EN
        push(K_ERR, int'(O_IC), -1);
        push(K_DROP, 1 + TO, -1);
`else
        push(K_LAST, 0, int'(O_IC));
        push(K_DROP, 14, -1);
`endif
        wait_gnt(ok);
        BUS_GNT = 1;
        idle(1);
        BUS_GNT = 0;
`ifdef LMI_ARB_TIMEOUT_EN
        idle(TO);
        IC_REQ = 0;
`else
        idle(12);
        chk("noack_hold_gnt", IC_GNT, 1);
        BUS_ACK = 1;
        idle(1);
        BUS_ACK = 0;
        IC_REQ = 0;
`endif
        idle(5);

        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL queue_drain: got %0d pending events, required 0",
                      q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
